vnu_serial: RTL and testbench

//  Serial, parametrised variable-node unit for the LDPC decoder. Takes one channel LLR l and D

---
 rtl/vnu_serial.sv | 123 ++++++++++++
 tb/tb_vnu_serial.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vnu_serial.sv
// Serial LDPC variable-node unit: D messages in, D extrinsic messages out, ping-pong banked.
// Define VNU_SAT_EN to clamp out_q to +/-(2^(DATA_W-1)-1).
module vnu_serial #(
  parameter int DATA_W = 6,
  parameter int D      = 6,
  parameter int EXT_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_l,
  input  logic [DATA_W-1:0]         in_r,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W+EXT_W-1:0]   out_q,
  output logic                      out_dec,
  output logic                      out_last
);

  localparam int SUM_W = DATA_W + EXT_W;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

  if (EXT_W < $clog2(D + 1)) begin : g_ext_w_check
    $error("vnu_serial: EXT_W too small to hold l + sum of D messages");
  end

  function automatic logic signed [SUM_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{EXT_W{v[DATA_W-1]}}, v};
  endfunction

  logic [DATA_W-1:0]        r_mem_q [2][D];
  logic signed [SUM_W-1:0]  s_q [2];
  logic signed [SUM_W-1:0]  s_d [2];
  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic                     wr_fire, rd_fire;
  logic signed [SUM_W-1:0]  q_full, q_res;

  // Handshakes depend only on registered full flags, never on the opposite side's inputs.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    s_d       = s_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;

    if (wr_fire) begin
      if (wr_idx_q == '0) s_d[wr_bank_q] = sext(in_l) + sext(in_r);
      else                s_d[wr_bank_q] = s_q[wr_bank_q] + sext(in_r);
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    // Fill and drain never target the same bank, so both updates can apply together.
    if (rd_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    q_full = s_q[rd_bank_q] - sext(r_mem_q[rd_bank_q][rd_idx_q]);
    q_res  = q_full;
`ifdef VNU_SAT_EN
    if (q_full > $signed(SUM_W'((2 ** (DATA_W - 1)) - 1)))
      q_res = $signed(SUM_W'((2 ** (DATA_W - 1)) - 1));
    else if (q_full < -$signed(SUM_W'((2 ** (DATA_W - 1)) - 1)))
      q_res = -$signed(SUM_W'((2 ** (DATA_W - 1)) - 1));
`endif
  end

  // Gate by out_valid so stale, unreset message storage never shows on the outputs.
  assign out_q    = out_valid ? q_res : '0;
  assign out_dec  = out_valid & s_q[rd_bank_q][SUM_W-1];
  assign out_last = out_valid & (rd_idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q[0]    <= '0;
      s_q[1]    <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      s_q       <= s_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // NOTE: message storage is deliberately unreset; full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) r_mem_q[wr_bank_q][wr_idx_q] <= in_r;
  end

endmodule

// File: tb/tb_vnu_serial.sv
// Self-checking bench for vnu_serial: directed vectors plus randomized nodes against
// an arithmetic reference model (honours VNU_SAT_EN).
module tb_vnu_serial;

  localparam int DATA_W = 6;
  localparam int D      = 6;
  localparam int EXT_W  = 3;
  localparam int SUM_W  = DATA_W + EXT_W;
  localparam int D2     = 2;
  localparam int EXT2_W = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid, in_ready;
  logic [DATA_W-1:0]         in_l, in_r;
  logic                      out_valid, out_ready;
  logic signed [SUM_W-1:0]   out_q;
  logic                      out_dec, out_last;

  logic                      d2_in_valid, d2_in_ready;
  logic [DATA_W-1:0]         d2_in_l, d2_in_r;
  logic                      d2_out_valid, d2_out_ready;
  logic signed [DATA_W+EXT2_W-1:0] d2_out_q;
  logic                      d2_out_dec, d2_out_last;

  vnu_serial #(.DATA_W(DATA_W), .D(D), .EXT_W(EXT_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_l(in_l), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_dec(out_dec), .out_last(out_last)
  );

  vnu_serial #(.DATA_W(DATA_W), .D(D2), .EXT_W(EXT2_W)) u_dut_d2 (
    .clk(clk), .rst(rst),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_l(d2_in_l), .in_r(d2_in_r),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_q(d2_out_q),
    .out_dec(d2_out_dec), .out_last(d2_out_last)
  );

  always #5 clk = ~clk;

  typedef struct { int q; bit dec; bit last; } beat_t;
  beat_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int node_l;
  int node_r [D];
  int ready_mode = 0;       // 0: always ready, 1: random, 2: scripted stall
  int stall_left, mode2_taken, taken, first_cyc, last_cyc, ready_low_cnt;
  bit stall_done;
  int cyc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_q(input int v);
`ifdef VNU_SAT_EN
    if (v > 31)  return 31;
    if (v < -31) return -31;
`endif
    return v;
  endfunction

  // Reference: s = l + sum(r); q_i = s - r_i; dec = sign(s).
  task automatic model_push();
    int s = node_l;
    for (int i = 0; i < D; i++) s += node_r[i];
    for (int i = 0; i < D; i++) exp_q.push_back('{clamp_q(s - node_r[i]), s < 0, i == D - 1});
  endtask

  task automatic send_beat(input int l, input int r, input bit gaps);
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_l     = DATA_W'(l);
    in_r     = DATA_W'(r);
    if (!in_ready) ready_low_cnt++;
    for (int t = 0; t < 300 && !in_ready; t++) @(negedge clk);
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic send_node(input bit gaps);
    model_push();
    for (int i = 0; i < D; i++) send_beat(node_l, node_r[i], gaps);
    in_valid = 1'b0;
  endtask

  task automatic rand_node();
    node_l = int'($urandom_range(0, 63)) - 32;
    for (int i = 0; i < D; i++) node_r[i] = int'($urandom_range(0, 63)) - 32;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) cyc++;

  // Output consumer and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else if (!stall_done && mode2_taken == 2) begin
            out_ready  = 1'b0;
            stall_left = 9;
            stall_done = 1'b1;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", out_valid, 0);
        end else begin
          check("out_q", out_q, exp_q[0].q);
          check("out_dec", out_dec, exp_q[0].dec);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (taken == 0) first_cyc = cyc;
            last_cyc = cyc;
            taken++;
            if (ready_mode == 2) mode2_taken++;
          end
        end
      end
    end
  end

  initial begin
    int vec_r [D];
    vec_r = '{1, -2, 3, -4, 10, -31};
    rst = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_l = '0; d2_in_r = '0; d2_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_dec", out_dec, 0);

    // Degree-2 instance: l=-3, r=7,-8 -> s=-4, q=-11,4.
    check("d2_in_ready", d2_in_ready, 1);
    d2_in_valid = 1'b1; d2_in_l = DATA_W'(-3); d2_in_r = DATA_W'(7);
    @(negedge clk);
    d2_in_r = DATA_W'(-8);
    @(negedge clk);
    d2_in_valid = 1'b0;
    check("d2_valid0", d2_out_valid, 1);
    check("d2_q0", d2_out_q, -11);
    check("d2_dec0", d2_out_dec, 1);
    check("d2_last0", d2_out_last, 0);
    @(negedge clk);
    check("d2_q1", d2_out_q, 4);
    check("d2_dec1", d2_out_dec, 1);
    check("d2_last1", d2_out_last, 1);
    @(negedge clk);
    check("d2_done", d2_out_valid, 0);

    // Directed vector with hand-computed results and latency check.
    ready_mode = 0;
    exp_q.push_back('{-19, 1'b1, 1'b0});
    exp_q.push_back('{-16, 1'b1, 1'b0});
    exp_q.push_back('{-21, 1'b1, 1'b0});
    exp_q.push_back('{-14, 1'b1, 1'b0});
    exp_q.push_back('{-28, 1'b1, 1'b0});
    exp_q.push_back('{13,  1'b1, 1'b1});
    for (int i = 0; i < D - 1; i++) send_beat(5, vec_r[i], 1'b0);
    check("pre_latency_valid", out_valid, 0);
    send_beat(5, vec_r[D-1], 1'b0);
    in_valid = 1'b0;
    check("latency_valid", out_valid, 1);
    wait_drain();

    // Magnitude extremes.
    node_l = 31;  for (int i = 0; i < D; i++) node_r[i] = 31;  send_node(1'b0);
    node_l = -31; for (int i = 0; i < D; i++) node_r[i] = -31; send_node(1'b0);
    wait_drain();

    // Three nodes back to back: no input stall, 18 contiguous output beats.
    taken = 0; ready_low_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      rand_node();
      model_push();
      for (int i = 0; i < D; i++) send_beat(node_l, node_r[i], 1'b0);
    end
    in_valid = 1'b0;
    wait_drain();
    check("b2b_in_ready_low", ready_low_cnt, 0);
    check("b2b_beats", taken, 3 * D);
    check("b2b_span", last_cyc - first_cyc + 1, 3 * D);

    // Output stall from beat 2 for 10 cycles while input keeps streaming.
    ready_low_cnt = 0; stall_left = 0; stall_done = 1'b0; mode2_taken = 0;
    ready_mode = 2;
    for (int n = 0; n < 3; n++) begin
      rand_node();
      model_push();
      for (int i = 0; i < D; i++) send_beat(node_l, node_r[i], 1'b0);
    end
    in_valid = 1'b0;
    wait_drain();
    check("stall_seen", int'(stall_done), 1);
    check("stall_in_ready_drop", int'(ready_low_cnt > 0), 1);
    ready_mode = 0;

    // Reset after beat 3 of a node; the next node must carry no residue.
    for (int i = 0; i < 4; i++) send_beat(int'($urandom_range(0, 63)) - 32, 31, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    rand_node();
    send_node(1'b0);
    wait_drain();

    // Randomized nodes with input gaps and random backpressure.
    ready_mode = 1;
    for (int n = 0; n < 25; n++) begin
      rand_node();
      send_node(1'b1);
    end
    wait_drain();
    check("final_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
